// File: rtl/classify_block_pipe2.sv
// rtl/classify_block_pipe2.sv - argmin classification and per-centroid coordinate accumulation
// Stage A registers the nearest enabled centroid; stage B adds the point into that accumulator.
module classify_block_pipe2 #(
  parameter int dataWidth        = 91,
  parameter int centroid_num     = 8,
  parameter int cordinate_width  = 13,
  parameter int accum_cord_width = 22,
  parameter int accum_width      = 154,
  parameter int count_width      = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [centroid_num*dataWidth-1:0]  distances,
  input  logic [dataWidth-1:0]               point_in,
  input  logic                               point_valid,
  input  logic [centroid_num-1:0]            active_mask,
  input  logic                               clear_accums,
  input  logic [2:0]                         rd_sel,
  output logic [accum_width-1:0]             accum_out,
  output logic [count_width-1:0]             count_out,
  output logic [2:0]                         class_id,
  output logic                               class_valid,
  output logic                               pipe_empty,
  output logic                               overflow
);

  localparam int num_coords = 7;
  localparam logic [accum_cord_width-1:0] acc_max = '1;
  localparam logic [count_width-1:0]      cnt_max = '1;

  logic [accum_width-1:0] acc [centroid_num];
  logic [count_width-1:0] cnt [centroid_num];

  logic                   valid_a;
  logic [2:0]             win_a;
  logic [dataWidth-1:0]   point_a;

  logic [2:0]             win_c;
  logic                   any_c;
  logic [dataWidth-1:0]   best_c;

  logic [accum_width-1:0]    row_sum;
  logic [count_width-1:0]    cnt_sum;
  logic [accum_cord_width:0] coord_sum;
  logic                      sat_c;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    win_c  = '0;
    any_c  = 1'b0;
    best_c = '0;
    for (int i = 0; i < centroid_num; i++) begin
      if (active_mask[i] && (!any_c || distances[i*dataWidth +: dataWidth] < best_c)) begin
        any_c  = 1'b1;
        best_c = distances[i*dataWidth +: dataWidth];
        win_c  = 3'(i);
      end
    end
  end

  // One extra carry bit per coordinate detects saturation.
  always_comb begin
    row_sum   = acc[win_a];
    coord_sum = '0;
    sat_c     = 1'b0;
    for (int j = 0; j < num_coords; j++) begin
      coord_sum = {1'b0, acc[win_a][j*accum_cord_width +: accum_cord_width]}
                + (accum_cord_width+1)'(point_a[j*cordinate_width +: cordinate_width]);
      if (coord_sum[accum_cord_width]) begin
        row_sum[j*accum_cord_width +: accum_cord_width] = acc_max;
        sat_c = 1'b1;
      end else begin
        row_sum[j*accum_cord_width +: accum_cord_width] = coord_sum[accum_cord_width-1:0];
      end
    end
    if (cnt[win_a] == cnt_max) begin
      cnt_sum = cnt_max;
      sat_c   = 1'b1;
    end else begin
      cnt_sum = cnt[win_a] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < centroid_num; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
      valid_a     <= 1'b0;
      win_a       <= '0;
      point_a     <= '0;
      class_id    <= '0;
      class_valid <= 1'b0;
      overflow    <= 1'b0;
      pipe_empty  <= 1'b1;
      accum_out   <= '0;
      count_out   <= '0;
    end else begin
      valid_a     <= point_valid & any_c;
      win_a       <= win_c;
      point_a     <= point_in;
      class_valid <= valid_a;
      if (valid_a) begin
        class_id <= win_a;
      end
      // class_valid doubles as the stage-B valid.
      pipe_empty <= !(valid_a | class_valid);
      accum_out  <= acc[rd_sel];
      count_out  <= cnt[rd_sel];
      if (clear_accums) begin
        for (int i = 0; i < centroid_num; i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
        overflow <= 1'b0;
      end else if (valid_a) begin
        acc[win_a] <= row_sum;
        cnt[win_a] <= cnt_sum;
        if (sat_c) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_classify_block_pipe2.sv
// tb/tb_classify_block_pipe2.sv - scoreboard bench for classify_block_pipe2
module tb_classify_block_pipe2;
  localparam int DW = 91, CN = 8, ACW = 22, AW = 154, CNTW = 10;
  localparam int ACC_MAX = 4194303, CNT_MAX = 1023;

  logic              clk = 1'b0;
  logic              rst;
  logic [CN*DW-1:0]  distances;
  logic [DW-1:0]     point_in;
  logic              point_valid;
  logic [CN-1:0]     active_mask;
  logic              clear_accums;
  logic [2:0]        rd_sel;
  logic [AW-1:0]     accum_out;
  logic [CNTW-1:0]   count_out;
  logic [2:0]        class_id;
  logic              class_valid;
  logic              pipe_empty;
  logic              overflow;

  always #5 clk = ~clk;

  classify_block_pipe2 dut (
    .clk(clk), .rst(rst), .distances(distances), .point_in(point_in),
    .point_valid(point_valid), .active_mask(active_mask), .clear_accums(clear_accums),
    .rd_sel(rd_sel), .accum_out(accum_out), .count_out(count_out), .class_id(class_id),
    .class_valid(class_valid), .pipe_empty(pipe_empty), .overflow(overflow)
  );

  int n_cmp = 0, n_bad = 0;

  // Reference state: what each accumulator holds after the most recent edge.
  int m_acc [CN][7];
  int m_cnt [CN];
  bit m_ovf;
  bit pend_v, prev_v;
  int pend_w;
  int pend_c [7];
  int exp_q [$];
  int mon_e;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_argmin(input logic [CN*DW-1:0] d, input logic [CN-1:0] m);
    int best = -1;
    logic [DW-1:0] bv = '0;
    logic [DW-1:0] v;
    for (int i = 0; i < CN; i++) begin
      if (m[i]) begin
        v = d[i*DW +: DW];
        if (best < 0 || v < bv) begin
          best = i;
          bv = v;
        end
      end
    end
    return best;
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < CN; i++) begin
      m_cnt[i] = 0;
      for (int j = 0; j < 7; j++) m_acc[i][j] = 0;
    end
    m_ovf = 1'b0;
  endfunction

  function automatic void model_apply();
    int s;
    for (int j = 0; j < 7; j++) begin
      s = m_acc[pend_w][j] + pend_c[j];
      if (s > ACC_MAX) begin
        s = ACC_MAX;
        m_ovf = 1'b1;
      end
      m_acc[pend_w][j] = s;
    end
    if (m_cnt[pend_w] == CNT_MAX) m_ovf = 1'b1;
    else m_cnt[pend_w]++;
  endfunction

  // One clock: snapshot expected readout, advance model at the edge, compare outputs.
  task automatic tick();
    logic [AW-1:0] er;
    int ec, rd, w;
    bit epe, acc_now;
    int c [7];
    rd = int'(rd_sel);
    for (int j = 0; j < 7; j++) er[j*ACW +: ACW] = ACW'(m_acc[rd][j]);
    ec = m_cnt[rd];
    epe = !(pend_v | prev_v);
    acc_now = point_valid && (active_mask != '0);
    w = ref_argmin(distances, active_mask);
    for (int j = 0; j < 7; j++) c[j] = int'(point_in[j*13 +: 13]);
    @(posedge clk);
    if (rst) begin
      model_zero();
      pend_v = 1'b0;
      prev_v = 1'b0;
      exp_q.delete();
      er = '0;
      ec = 0;
      epe = 1'b1;
    end else begin
      if (clear_accums) model_zero();
      else if (pend_v) model_apply();
      prev_v = pend_v;
      pend_v = acc_now;
      if (acc_now) begin
        pend_w = w;
        pend_c = c;
        exp_q.push_back(w);
      end
    end
    #1;
    check("accum_out", 160'(accum_out), 160'(er));
    check("count_out", 160'(count_out), 160'(ec));
    check("pipe_empty", 160'(pipe_empty), 160'(epe));
    check("overflow", 160'(overflow), 160'(m_ovf));
  endtask

  always @(negedge clk) begin
    if (class_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL class_valid: got pulse expected none at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("class_id", 160'(class_id), 160'(mon_e));
      end
    end
  end

  function automatic logic [CN*DW-1:0] dist_min_at(input int k);
    logic [CN*DW-1:0] d;
    for (int i = 0; i < CN; i++) d[i*DW +: DW] = DW'(1000 + $urandom_range(0, 100000));
    d[k*DW +: DW] = DW'($urandom_range(0, 999));
    return d;
  endfunction

  function automatic logic [DW-1:0] pt_all(input int v);
    logic [DW-1:0] p;
    for (int j = 0; j < 7; j++) p[j*13 +: 13] = 13'(v);
    return p;
  endfunction

  function automatic logic [DW-1:0] pt_rand();
    logic [DW-1:0] p;
    for (int j = 0; j < 7; j++) p[j*13 +: 13] = 13'($urandom_range(0, 8191));
    return p;
  endfunction

  task automatic send(input logic [CN*DW-1:0] d, input logic [DW-1:0] p, input logic [CN-1:0] m);
    distances = d;
    point_in = p;
    active_mask = m;
    point_valid = 1'b1;
    tick();
    point_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_clear();
    clear_accums = 1'b1;
    tick();
    clear_accums = 1'b0;
  endtask

  logic [CN*DW-1:0] dtie;
  logic [AW-1:0] row_exp;

  initial begin
    model_zero();
    pend_v = 1'b0;
    prev_v = 1'b0;
    rst = 1'b1;
    distances = '0;
    point_in = '0;
    point_valid = 1'b0;
    active_mask = '0;
    clear_accums = 1'b0;
    rd_sel = '0;
    tick();
    tick();
    check("reset class_valid", 160'(class_valid), 160'(0));
    check("reset class_id", 160'(class_id), 160'(0));
    rst = 1'b0;
    idle(2);

    // Nearest is centroid 3, all coordinates 5.
    rd_sel = 3'd3;
    send(dist_min_at(3), pt_all(5), 8'hFF);
    idle(3);
    for (int j = 0; j < 7; j++) row_exp[j*ACW +: ACW] = 22'd5;
    check("t2 count3", 160'(count_out), 160'(1));
    check("t2 acc3", 160'(accum_out), 160'(row_exp));

    // Tie between 1 and 6; masking 1 out moves the winner to 6; empty mask drops the point.
    for (int i = 0; i < CN; i++) dtie[i*DW +: DW] = DW'(100);
    dtie[1*DW +: DW] = DW'(10);
    dtie[6*DW +: DW] = DW'(10);
    send(dtie, pt_rand(), 8'hFF);
    send(dtie, pt_rand(), 8'hFD);
    send(dtie, pt_rand(), 8'h00);
    idle(3);
    rd_sel = 3'd1;
    idle(2);
    check("t3 count1", 160'(count_out), 160'(1));
    rd_sel = 3'd6;
    idle(2);
    check("t3 count6", 160'(count_out), 160'(1));

    // Reset with points in flight: nothing emerges and all counts read back zero.
    point_valid = 1'b1;
    distances = dist_min_at(2);
    point_in = pt_rand();
    active_mask = 8'hFF;
    tick();
    rst = 1'b1;
    tick();
    check("t1 pipe_empty", 160'(pipe_empty), 160'(1));
    rst = 1'b0;
    point_valid = 1'b0;
    for (int i = 0; i < CN; i++) begin
      rd_sel = 3'(i);
      idle(2);
      check("t1 count zero", 160'(count_out), 160'(0));
    end

    // Saturation of centroid 0.
    rd_sel = 3'd0;
    for (int k = 0; k < 1024; k++) send(dist_min_at(0), pt_all(8191), 8'hFF);
    idle(3);
    for (int j = 0; j < 7; j++) row_exp[j*ACW +: ACW] = 22'(ACC_MAX);
    check("t4 count sat", 160'(count_out), 160'(CNT_MAX));
    check("t4 acc sat", 160'(accum_out), 160'(row_exp));
    check("t4 overflow", 160'(overflow), 160'(1));
    do_clear();
    idle(2);
    check("t4 count cleared", 160'(count_out), 160'(0));
    check("t4 overflow cleared", 160'(overflow), 160'(0));

    // Back-to-back alternating winners.
    for (int k = 0; k < 100; k++) send(dist_min_at((k % 2) ? 7 : 0), pt_rand(), 8'hFF);
    idle(3);
    check("t5 count0", 160'(count_out), 160'(50));
    rd_sel = 3'd7;
    idle(2);
    check("t5 count7", 160'(count_out), 160'(50));

    // Clear coincident with a stage-B update; the following point survives.
    do_clear();
    idle(3);
    rd_sel = 3'd2;
    send(dist_min_at(2), pt_all(3), 8'hFF);
    clear_accums = 1'b1;
    send(dist_min_at(2), pt_all(4), 8'hFF);
    clear_accums = 1'b0;
    tick();
    check("t6 read during update", 160'(count_out), 160'(0));
    tick();
    check("t6 count after clear", 160'(count_out), 160'(1));
    for (int j = 0; j < 7; j++) row_exp[j*ACW +: ACW] = 22'd4;
    check("t6 acc after clear", 160'(accum_out), 160'(row_exp));

    // Random traffic with small distances (many ties) and the MSB toggled.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CN; i++)
        distances[i*DW +: DW] = {1'($urandom_range(0, 1)), 58'b0, 32'($urandom_range(0, 7))};
      point_in = pt_rand();
      point_valid = ($urandom_range(0, 3) != 0);
      active_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      clear_accums = ($urandom_range(0, 32) == 0);
      rst = ($urandom_range(0, 99) == 0);
      rd_sel = 3'($urandom);
      tick();
    end
    rst = 1'b0;
    point_valid = 1'b0;
    clear_accums = 1'b0;
    idle(4);
    check("scoreboard drained", 160'(exp_q.size()), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
